// File: rtl/ahb2apb_nslave26_if.sv
// Bus bundle for the AHB-lite to APB bridge: AHB slave-side signals plus the
// APB master-side fan-out to NUM_SLAVES peripherals.
interface ahb2apb_nslave26_if #(
   parameter int NUM_SLAVES = 8,
   parameter int DATA_WIDTH = 32
);
   logic                             hsel26;
   logic [31:0]                      haddr26;
   logic [1:0]                       htrans26;
   logic                             hwrite26;
   logic [DATA_WIDTH-1:0]            hwdata26;
   logic                             hready_in26;
   logic [DATA_WIDTH-1:0]            hrdata26;
   logic                             hready26;
   logic [1:0]                       hresp26;
   logic [31:0]                      paddr26;
   logic                             pwrite26;
   logic                             penable26;
   logic [DATA_WIDTH-1:0]            pwdata26;
   logic [NUM_SLAVES-1:0]            psel26;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata26;
   logic [NUM_SLAVES-1:0]            pready26;
   logic [NUM_SLAVES-1:0]            pslverr26;
   logic                             timeout26;

   // bridge view
   modport slave (
      input  hsel26, haddr26, htrans26, hwrite26, hwdata26, hready_in26,
      input  prdata26, pready26, pslverr26,
      output hrdata26, hready26, hresp26,
      output paddr26, pwrite26, penable26, pwdata26, psel26, timeout26
   );

   // environment view: AHB master plus the APB peripherals
   modport master (
      output hsel26, haddr26, htrans26, hwrite26, hwdata26, hready_in26,
      output prdata26, pready26, pslverr26,
      input  hrdata26, hready26, hresp26,
      input  paddr26, pwrite26, penable26, pwdata26, psel26, timeout26
   );
endinterface

// File: rtl/ahb2apb_nslave26.sv
// AHB-lite to APB bridge with NUM_SLAVES equal windows, PSLVERR propagation,
// ACCESS wait-state timeout and ERROR response for unmapped addresses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | hready high, waiting for a NONSEQ/SEQ address phase
// CAPTURE | latch write data, APB address already registered
// SETUP   | psel high, penable low, timeout counter cleared
// ACCESS  | psel+penable high, waiting for pready or timeout
// ERR1    | first ERROR cycle, hready low
// ERR2    | second ERROR cycle, hready high, no new accept
module ahb2apb_nslave26 #(
   parameter int          NUM_SLAVES     = 8,
   parameter logic [31:0] BASE_ADDR      = 32'h00A0_0000,
   parameter int          WIN_LOG2       = 16,
   parameter int          DATA_WIDTH     = 32,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic               hclk26,
   input  logic               hreset26,
   ahb2apb_nslave26_if.slave  bus
);

   localparam int          IDXW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [31:0] WIN_MASK = 32'((64'd1 << WIN_LOG2) - 64'd1);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic                  pwrite_q, pwrite_d;
   logic [31:0]           paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  timeout_q, timeout_d;

   logic [31:0]           offset;
   logic [31:0]           win_idx;
   logic                  in_range;
   logic                  accept;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                  tmo_hit;

   assign offset    = bus.haddr26 - BASE_ADDR;
   assign win_idx   = offset >> WIN_LOG2;
   assign in_range  = (bus.haddr26 >= BASE_ADDR) && (win_idx < 32'(NUM_SLAVES));
   assign accept    = bus.hsel26 && bus.hready_in26 && bus.htrans26[1] && (state_q == S_IDLE);

   // only the selected slave's handshake is ever looked at
   assign sel_ready = bus.pready26[idx_q];
   assign sel_err   = bus.pslverr26[idx_q];
   assign sel_rdata = bus.prdata26[idx_q*DATA_WIDTH +: DATA_WIDTH];
   assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == 16'(TIMEOUT_CYCLES)) && !sel_ready;

   always_ff @(posedge hclk26 or posedge hreset26) begin
      if (hreset26) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         hrdata_q  <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         hrdata_q  <= hrdata_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      hrdata_d  = hrdata_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (in_range) begin
                  idx_d    = IDXW'(win_idx);
                  paddr_d  = offset & WIN_MASK;
                  pwrite_d = bus.hwrite26;
                  state_d  = S_CAPTURE;
               end else begin
                  state_d  = S_ERR1;
               end
            end
         end
         S_CAPTURE: begin
            if (pwrite_q) pwdata_d = bus.hwdata26;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 16'd1;
            if (sel_ready) begin
               if (sel_err) begin
                  state_d = S_ERR1;
               end else begin
                  if (!pwrite_q) hrdata_d = sel_rdata;
                  state_d = S_IDLE;
               end
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               state_d   = S_ERR1;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         S_ERR2:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.hready26  = (state_q == S_IDLE) || (state_q == S_ERR2);
   assign bus.hresp26   = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
   assign bus.hrdata26  = hrdata_q;
   assign bus.paddr26   = paddr_q;
   assign bus.pwrite26  = pwrite_q;
   assign bus.pwdata26  = pwdata_q;
   assign bus.penable26 = (state_q == S_ACCESS);
   assign bus.psel26    = ((state_q == S_SETUP) || (state_q == S_ACCESS))
                          ? (NUM_SLAVES'(1) << idx_q) : '0;
   assign bus.timeout26 = timeout_q;

endmodule

// File: tb/tb_ahb2apb_nslave26.sv
// Directed bench for ahb2apb_nslave26: stimulus pushes expectations into
// queues, a negedge monitor pops and compares on each AHB completion and APB setup.
module tb_ahb2apb_nslave26;
   localparam int NS = 8;
   localparam int DW = 32;

   logic hclk26;
   logic hreset26;

   ahb2apb_nslave26_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) bus ();

   ahb2apb_nslave26 #(
      .NUM_SLAVES(NS), .BASE_ADDR(32'h00A0_0000), .WIN_LOG2(16),
      .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)
   ) dut (
      .hclk26  (hclk26),
      .hreset26(hreset26),
      .bus     (bus.slave)
   );

   initial hclk26 = 1'b0;
   always #5 hclk26 = ~hclk26;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      bit          chk_rd;
      int          waits;
      int          setups;
      int          tmos;
   } ahb_exp_t;

   typedef struct {
      logic [31:0] paddr;
      logic [7:0]  psel;
      logic        pwrite;
      logic [31:0] pwdata;
   } apb_exp_t;

   ahb_exp_t ahb_q[$];
   apb_exp_t apb_q[$];

   int n_cmp = 0;
   int n_mis = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // APB peripheral model: unselected slaves drive ready/error high to prove they are ignored
   int          wait_cfg[NS];
   bit          err_cfg[NS];
   logic [31:0] rd_cfg[NS];
   int          acc_n = 0;

   for (genvar g = 0; g < NS; g++) begin : g_prdata
      assign bus.prdata26[g*DW +: DW] = rd_cfg[g];
   end

   always @(posedge hclk26) begin
      logic [NS-1:0] pr, pe;
      #1;
      if (bus.psel26 != 0 && bus.penable26) acc_n++;
      else acc_n = 0;
      pr = ~bus.psel26;
      pe = ~bus.psel26;
      for (int i = 0; i < NS; i++) begin
         if (bus.psel26[i]) begin
            if (bus.penable26 && wait_cfg[i] >= 0 && acc_n > wait_cfg[i]) begin
               pr[i] = 1'b1;
               pe[i] = err_cfg[i];
            end else begin
               pr[i] = 1'b0;
               pe[i] = 1'b1;
            end
         end
      end
      bus.pready26  = pr;
      bus.pslverr26 = pe;
   end

   // monitor
   bit active = 0;
   int m_waits, m_setups, m_tmos;

   always @(negedge hclk26) begin
      ahb_exp_t ea;
      apb_exp_t ep;
      if (hreset26) begin
         active = 0;
      end else begin
         if (active) begin
            if (!bus.hready26) begin
               m_waits++;
               if (bus.timeout26) m_tmos++;
            end else begin
               active = 0;
               if (ahb_q.size() == 0) begin
                  chk("unexpected_completion", 1, 0);
               end else begin
                  ea = ahb_q.pop_front();
                  chk("hresp", bus.hresp26, ea.resp);
                  chk("wait_states", m_waits, ea.waits);
                  chk("psel_setups", m_setups, ea.setups);
                  chk("timeout_pulses", m_tmos, ea.tmos);
                  if (ea.chk_rd) chk("hrdata", bus.hrdata26, ea.rdata);
               end
            end
         end
         if (bus.psel26 != 0 && !bus.penable26) begin
            m_setups++;
            if (apb_q.size() == 0) begin
               chk("unexpected_setup", 1, 0);
            end else begin
               ep = apb_q.pop_front();
               chk("paddr", bus.paddr26, ep.paddr);
               chk("psel", bus.psel26, ep.psel);
               chk("pwrite", bus.pwrite26, ep.pwrite);
               if (ep.pwrite) chk("pwdata", bus.pwdata26, ep.pwdata);
            end
         end
         if (bus.hresp26 == 2'b01 && bus.psel26 != 0) chk("psel_during_error", bus.psel26, 0);
         if (bus.hsel26 && bus.htrans26[1] && bus.hready_in26 && bus.hready26 && bus.hresp26 == 2'b00) begin
            active   = 1;
            m_waits  = 0;
            m_setups = 0;
            m_tmos   = 0;
         end
      end
   end

   // stimulus helpers; entered and left at posedge+1
   task automatic drive_addr(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
      bus.hsel26   = 1'b1;
      bus.haddr26  = addr;
      bus.htrans26 = 2'b10;
      bus.hwrite26 = wr;
      @(posedge hclk26); #1;
      bus.hsel26   = 1'b0;
      bus.htrans26 = 2'b00;
      bus.hwdata26 = wdata;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bus.hready26 && n < 2000) begin
         @(posedge hclk26); #1;
         n++;
      end
      if (n >= 2000) chk("completion_budget", n, 0);
   endtask

   task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [1:0] e_resp, input logic [31:0] e_rdata,
                        input int e_waits, input int e_setups, input int e_tmos,
                        input logic [31:0] e_paddr, input logic [7:0] e_psel);
      ahb_exp_t ea;
      apb_exp_t ep;
      ea.resp   = e_resp;
      ea.rdata  = e_rdata;
      ea.chk_rd = !wr && (e_resp == 2'b00);
      ea.waits  = e_waits;
      ea.setups = e_setups;
      ea.tmos   = e_tmos;
      ahb_q.push_back(ea);
      if (e_setups > 0) begin
         ep.paddr  = e_paddr;
         ep.psel   = e_psel;
         ep.pwrite = wr;
         ep.pwdata = wdata;
         apb_q.push_back(ep);
      end
      drive_addr(addr, wr, wdata);
      wait_done();
   endtask

   task automatic idle_cycle();
      @(posedge hclk26); #1;
   endtask

   initial begin
      apb_exp_t ep;
      int n;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      apb_exp_t ep;
      int n;
      hreset26        = 1'b1;
      bus.hsel26      = 1'b0;
      bus.haddr26     = '0;
      bus.htrans26    = 2'b00;
      bus.hwrite26    = 1'b0;
      bus.hwdata26    = '0;
      bus.hready_in26 = 1'b1;
      for (int i = 0; i < NS; i++) begin
         wait_cfg[i] = 0;
         err_cfg[i]  = 1'b0;
         rd_cfg[i]   = 32'hA5A5_0000 | i;
      end
      repeat (3) @(posedge hclk26);
      #1;
      chk("rst_hready", bus.hready26, 1);
      chk("rst_hresp", bus.hresp26, 0);
      chk("rst_psel", bus.psel26, 0);
      chk("rst_penable", bus.penable26, 0);
      chk("rst_hrdata", bus.hrdata26, 0);
      chk("rst_timeout", bus.timeout26, 0);
      hreset26 = 1'b0;
      idle_cycle();

      // IDLE and BUSY with hsel: no APB activity, zero wait
      bus.hsel26 = 1'b1;
      bus.haddr26 = 32'h00A3_0000;
      for (int t = 0; t < 4; t++) begin
         bus.htrans26 = (t < 2) ? 2'b00 : 2'b01;
         idle_cycle();
         chk("idlebusy_hready", bus.hready26, 1);
         chk("idlebusy_psel", bus.psel26, 0);
      end
      bus.hsel26 = 1'b0;
      bus.htrans26 = 2'b00;

      // write slave 3, ready on first ACCESS
      issue(32'h00A3_0010, 1, 32'hDEAD_BEEF, 2'b00, 0, 3, 1, 0, 32'h10, 8'b0000_1000);
      // read slave 1, 5 ACCESS wait cycles
      wait_cfg[1] = 5; rd_cfg[1] = 32'h1234_5678;
      issue(32'h00A1_0004, 0, 0, 2'b00, 32'h1234_5678, 8, 1, 0, 32'h4, 8'b0000_0010);
      // index 8: out of range
      issue(32'h00A8_0000, 0, 0, 2'b01, 0, 1, 0, 0, 0, 0);
      idle_cycle();
      // slave 2 never ready: 2 + 256 ACCESS + ERR1
      wait_cfg[2] = -1;
      issue(32'h00A2_0008, 0, 0, 2'b01, 0, 259, 1, 1, 32'h8, 8'b0000_0100);
      idle_cycle();
      // slave 5 write error
      err_cfg[5] = 1'b1;
      issue(32'h00A5_0020, 1, 32'hCAFE_F00D, 2'b01, 0, 4, 1, 0, 32'h20, 8'b0010_0000);
      idle_cycle();
      // back-to-back: read top of slave 7, then write slave 0 with 2 waits
      rd_cfg[7] = 32'h7777_AAAA; wait_cfg[0] = 2;
      issue(32'h00A7_FFFC, 0, 0, 2'b00, 32'h7777_AAAA, 3, 1, 0, 32'hFFFC, 8'b1000_0000);
      issue(32'h00A0_0000, 1, 32'h55AA_33CC, 2'b00, 0, 5, 1, 0, 32'h0, 8'b0000_0001);
      // just below the base
      issue(32'h009F_FFFC, 0, 0, 2'b01, 0, 1, 0, 0, 0, 0);
      idle_cycle();

      // reset during ACCESS of a read to slave 2 (never ready)
      ep.paddr = 32'h44; ep.psel = 8'b0000_0100; ep.pwrite = 1'b0; ep.pwdata = 0;
      apb_q.push_back(ep);
      drive_addr(32'h00A2_0044, 0, 0);
      n = 0;
      while (!bus.penable26 && n < 50) begin
         idle_cycle();
         n++;
      end
      chk("pre_rst_penable", bus.penable26, 1);
      hreset26 = 1'b1;
      #1;
      chk("mid_rst_hready", bus.hready26, 1);
      chk("mid_rst_hresp", bus.hresp26, 0);
      chk("mid_rst_psel", bus.psel26, 0);
      chk("mid_rst_penable", bus.penable26, 0);
      chk("mid_rst_paddr", bus.paddr26, 0);
      chk("mid_rst_pwdata", bus.pwdata26, 0);
      chk("mid_rst_pwrite", bus.pwrite26, 0);
      chk("mid_rst_hrdata", bus.hrdata26, 0);
      chk("mid_rst_timeout", bus.timeout26, 0);
      idle_cycle();
      hreset26 = 1'b0;
      idle_cycle();

      wait_cfg[0] = 0; rd_cfg[0] = 32'h0BAD_C0DE;
      issue(32'h00A0_0000, 0, 0, 2'b00, 32'h0BAD_C0DE, 3, 1, 0, 32'h0, 8'b0000_0001);
      repeat (3) idle_cycle();

      chk("ahb_queue_drained", ahb_q.size(), 0);
      chk("apb_queue_drained", apb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/ahb2apb_nslave26.md
Name: ahb2apb_nslave26

Overview:
Parametrised single-clock AHB-lite to APB bridge. It replaces a fixed five-slave bridge with N contiguous equal-size APB windows. It adds per-slave PSLVERR propagation, an APB wait-state timeout with error abort, and out-of-range AHB ERROR responses. It sits between the AHB fabric and the peripheral cluster (ALUT, MACs, future slaves).

Parameters:
NUM_SLAVES, 8, number of APB slave windows (1..16)
BASE_ADDR, 32'h00A00000, start address of slave 0 window
WIN_LOG2, 16, log2 of window size in bytes; slave i spans BASE_ADDR + i*2^WIN_LOG2 .. +2^WIN_LOG2-1
DATA_WIDTH, 32, AHB/APB data width
TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready; 0 disables timeout (16-bit counter)

Ports:
hclk26  in  1  bridge clock; AHB and APB share it
hreset26  in  1  asynchronous, active-high reset
hsel26  in  1  AHB slave select
haddr26  in  32  AHB address
htrans26  in  2  AHB transfer type
hwrite26  in  1  AHB write
hwdata26  in  DATA_WIDTH  AHB write data
hready_in26  in  1  AHB global ready
hrdata26  out  DATA_WIDTH  AHB read data
hready26  out  1  AHB ready out
hresp26  out  2  AHB response (00 OKAY, 01 ERROR)
paddr26  out  32  APB address (haddr offset within window, upper bits zero)
pwrite26  out  1  APB write
penable26  out  1  APB enable
pwdata26  out  DATA_WIDTH  APB write data
psel26  out  NUM_SLAVES  one-hot APB selects
prdata26  in  NUM_SLAVES*DATA_WIDTH  concatenated read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
pready26  in  NUM_SLAVES  per-slave ready
pslverr26  in  NUM_SLAVES  per-slave error
timeout26  out  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - hrdata26, paddr26, pwdata26 = 0; pwrite26, penable26, psel26 = 0
  - hready26 = 1; hresp26 = OKAY; timeout26 = 0; FSM = IDLE; timeout counter = 0
- Accept condition: hsel26 & hready_in26 & htrans26[1] & state IDLE. Register haddr26, hwrite26, and decode at the clock edge.
- IDLE or BUSY htrans with hsel: no APB activity; hready26 stays 1, OKAY.
- Decode: offset = haddr26 - BASE_ADDR; index = offset >> WIN_LOG2. In range iff haddr26 >= BASE_ADDR and index < NUM_SLAVES.
- FSM states:
  - IDLE: hready26=1. On accept: in range -> CAPTURE; out of range -> ERR1.
  - CAPTURE: hready26=0; register hwdata26 into pwdata26 (writes only; reads leave pwdata26 unchanged); drive paddr26 = offset mod 2^WIN_LOG2. -> SETUP.
  - SETUP: psel26[index]=1, penable26=0, hready26=0; clear timeout counter. -> ACCESS.
  - ACCESS: psel26[index]=1, penable26=1, hready26=0; counter increments each cycle.
    - On pready26[index]=1 with pslverr26[index]=0: register prdata slice into hrdata26 (reads only), drop psel/penable -> IDLE (OKAY).
    - On pready26[index]=1 with pslverr26[index]=1 -> ERR1.
    - If TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES and pready26 low: drop psel/penable, pulse timeout26 -> ERR1.
    - pready has priority over timeout in the same cycle.
  - ERR1: hready26=0, hresp26=ERROR. -> ERR2.
  - ERR2: hready26=1, hresp26=ERROR. -> IDLE. A new transfer is not accepted in ERR2.
- Latency: OKAY transfers insert 3 + (ACCESS wait cycles) AHB wait states. hrdata26 is valid while hready26=1 in the first IDLE cycle.
- Back-to-back: the next address phase may be accepted in that same IDLE cycle.
- Outputs:
  - psel26 is zero outside SETUP and ACCESS, and at most one bit is high.
  - paddr26, pwrite26, pwdata26 are stable from SETUP through end of ACCESS.
  - hrdata26 holds its last value otherwise.
- pready26/pslverr26 of unselected slaves are ignored.

Test Plan:
- Write 0xDEADBEEF to 0x00A30010, pready26[3] high on first ACCESS cycle:
  - paddr26=0x10, psel26=8'b00001000, pwdata26=0xDEADBEEF, pwrite26=1.
  - Exactly 3 hready26-low cycles, OKAY.
- Read 0x00A10004, slave 1 holds pready low 5 cycles then returns 0x12345678:
  - 8 wait states, hrdata26=0x12345678, OKAY.
- Read 0x00A80000 (index 8, out of range):
  - No psel activity; ERR1 then ERR2 (hready 0 then 1, hresp 01).
- Slave 2 never asserts pready, TIMEOUT_CYCLES=255:
  - psel drops after ACCESS counter reaches 255; timeout26 pulses once; two-cycle ERROR.
- Slave 5 returns pready=1, pslverr=1 on a write:
  - Two-cycle ERROR, timeout26 stays 0.
- Assert hreset26 during ACCESS of a read:
  - All outputs at reset values within the same cycle.
  - After release, a read of 0x00A00000 completes normally.
